// File: rtl/apb_pkg.sv
// Shared types and constants for the APB3 register completer.
package apb_pkg;

    // Bus-side FSM: IDLE waits for a setup phase, ACCESS counts wait states
    // and completes the transfer.
    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_state_e;

    // Byte offsets of the fixed registers; everything from SCRATCH_BASE up is scratch.
    localparam logic [31:0] ID_OFF       = 32'h0000_0000;
    localparam logic [31:0] CTRL_OFF     = 32'h0000_0004;
    localparam logic [31:0] STATUS_OFF   = 32'h0000_0008;
    localparam logic [31:0] SCRATCH_BASE = 32'h0000_000C;

    localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA9B0_0001;

    localparam int WAIT_W = 4;
    localparam int CNT_W  = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/apb_regbank.sv
// Register bank behind the APB completer: address decode, error detection,
// ID/CTRL/STATUS/scratch storage and the saturating transfer counters.
// rd_data_o and err_o are purely combinational from the address, direction and
// stored state; the bank only changes state on a commit pulse.
module apb_regbank
    import apb_pkg::*;
#(
    parameter int                 NUM_REGS     = 16,
    parameter logic [WAIT_W-1:0]  WAIT_DEFAULT = '0,
    parameter logic [31:0]        ID_VALUE     = ID_VALUE_DEFAULT
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic [31:0]        addr_i,
    input  logic               write_i,
    input  logic [31:0]        wdata_i,
    input  logic               commit_i,
    output logic [31:0]        rd_data_o,
    output logic               err_o,
    output logic [WAIT_W-1:0]  wait_o
);

    localparam int          IDX_W       = $clog2(NUM_REGS);
    localparam logic [31:0] ADDR_LIMIT  = 32'(NUM_REGS * 4);
    localparam logic [IDX_W-1:0] ID_IDX      = ID_OFF[IDX_W+1:2];
    localparam logic [IDX_W-1:0] CTRL_IDX    = CTRL_OFF[IDX_W+1:2];
    localparam logic [IDX_W-1:0] STATUS_IDX  = STATUS_OFF[IDX_W+1:2];
    localparam logic [IDX_W-1:0] SCRATCH_IDX = SCRATCH_BASE[IDX_W+1:2];

    logic [WAIT_W-1:0] ctrl_wait_q, ctrl_wait_d;
    logic [CNT_W-1:0]  wr_cnt_q,    wr_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q,   err_cnt_d;
    logic [31:0]       scratch_q [NUM_REGS];
    logic [31:0]       scratch_d [NUM_REGS];

    logic [IDX_W-1:0]  idx;
    logic              misalign;
    logic              out_of_range;
    logic              ro_write;
    logic              is_scratch;

    // Word index and error classification. Out-of-range addresses alias onto
    // idx, but err_o masks every effect of that aliasing.
    always_comb begin
        idx          = addr_i[IDX_W+1:2];
        misalign     = |addr_i[1:0];
        out_of_range = (addr_i >= ADDR_LIMIT);
        ro_write     = write_i && ((idx == ID_IDX) || (idx == STATUS_IDX));
        is_scratch   = (idx >= SCRATCH_IDX);
        err_o        = misalign | out_of_range | ro_write;
    end

    // Read mux; only the top gates this onto PRDATA, so no PWDATA path exists.
    always_comb begin
        rd_data_o = '0;
        if (idx == ID_IDX) begin
            rd_data_o = ID_VALUE;
        end else if (idx == CTRL_IDX) begin
            rd_data_o = {{(32-WAIT_W){1'b0}}, ctrl_wait_q};
        end else if (idx == STATUS_IDX) begin
            rd_data_o = {err_cnt_q, wr_cnt_q};
        end else if (is_scratch) begin
            rd_data_o = scratch_q[idx];
        end
    end

    // Next-state for storage and counters; only a commit changes anything.
    always_comb begin
        ctrl_wait_d = ctrl_wait_q;
        wr_cnt_d    = wr_cnt_q;
        err_cnt_d   = err_cnt_q;
        scratch_d   = scratch_q;
        if (commit_i) begin
            if (err_o) begin
                err_cnt_d = sat_inc(err_cnt_q);
            end else if (write_i) begin
                wr_cnt_d = sat_inc(wr_cnt_q);
                if (idx == CTRL_IDX) begin
                    ctrl_wait_d = wdata_i[WAIT_W-1:0];
                end else if (is_scratch) begin
                    scratch_d[idx] = wdata_i;
                end
            end
        end
    end

    // Register state with asynchronous active-low reset.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ctrl_wait_q <= WAIT_DEFAULT;
            wr_cnt_q    <= '0;
            err_cnt_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                scratch_q[i] <= '0;
            end
        end else begin
            ctrl_wait_q <= ctrl_wait_d;
            wr_cnt_q    <= wr_cnt_d;
            err_cnt_q   <= err_cnt_d;
            scratch_q   <= scratch_d;
        end
    end

    assign wait_o = ctrl_wait_q;

endmodule

// File: rtl/apb_completer_regs.sv
// APB3 completer with programmable wait states in front of apb_regbank.
//
//  state  | meaning
//  -------+--------------------------------------------------------------
//  IDLE   | no transfer in flight; a setup phase loads the wait counter
//  ACCESS | access phase; PREADY rises once the wait counter reaches 0
//
// The wait counter is loaded at setup, so a CTRL.WAIT write only affects the
// following transfer. Dropping PSEL during ACCESS aborts without side effects.
module apb_completer_regs
    import apb_pkg::*;
#(
    parameter int                 NUM_REGS     = 16,
    parameter logic [WAIT_W-1:0]  WAIT_DEFAULT = '0,
    parameter logic [31:0]        ID_VALUE     = ID_VALUE_DEFAULT
) (
    input  logic         PCLK,
    input  logic         PRESETn,
    input  logic         PSEL,
    input  logic         PENABLE,
    input  logic         PWRITE,
    input  logic [31:0]  PADDR,
    input  logic [31:0]  PWDATA,
    output logic [31:0]  PRDATA,
    output logic         PREADY,
    output logic         PSLVERR
);

    apb_state_e        state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

    logic [31:0]       rd_data;
    logic              err;
    logic [WAIT_W-1:0] ctrl_wait;
    logic              complete;
    logic              commit;

    apb_regbank #(
        .NUM_REGS     (NUM_REGS),
        .WAIT_DEFAULT (WAIT_DEFAULT),
        .ID_VALUE     (ID_VALUE)
    ) u_regbank (
        .PCLK      (PCLK),
        .PRESETn   (PRESETn),
        .addr_i    (PADDR),
        .write_i   (PWRITE),
        .wdata_i   (PWDATA),
        .commit_i  (commit),
        .rd_data_o (rd_data),
        .err_o     (err),
        .wait_o    (ctrl_wait)
    );

    // Completion is a function of registered state only; commit also needs PSEL
    // so an abort landing on the final access cycle still has no side effects.
    assign complete = (state_q == ACCESS) && (wait_cnt_q == '0);
    assign commit   = complete && PSEL;

    // FSM next-state and wait-counter control.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (PSEL && !PENABLE) begin
                    state_d    = ACCESS;
                    wait_cnt_d = ctrl_wait;
                end
            end
            ACCESS: begin
                if (!PSEL) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - {{(WAIT_W-1){1'b0}}, 1'b1};
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // FSM and wait-counter registers.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Response outputs, forced to 0 outside the completing cycle.
    always_comb begin
        PREADY  = complete;
        PSLVERR = complete && err;
        PRDATA  = (complete && !PWRITE && !err) ? rd_data : 32'h0;
    end

endmodule

// File: tb/tb_apb_completer_regs.sv
// Self-checking bench for apb_completer_regs: scoreboard of expected responses
// built from a small register model, compared when PREADY is seen.
module tb_apb_completer_regs;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        PSEL, PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic        PREADY, PSLVERR;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          waits;
    } exp_t;

    exp_t sb[$];

    logic [31:0] m_scr [16];
    logic [3:0]  m_ctrl;
    logic [15:0] m_wr, m_err;

    apb_completer_regs dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .PSLVERR (PSLVERR)
    );

    always #5 PCLK = ~PCLK;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_scr[i] = 32'h0;
        m_ctrl = 4'h0;
        m_wr   = 16'h0;
        m_err  = 16'h0;
    endtask

    function automatic logic exp_err(input logic wr, input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'd64) || (wr && (a == 32'h0 || a == 32'h8));
    endfunction

    function automatic logic [31:0] exp_data(input logic wr, input logic [31:0] a);
        logic [3:0] w;
        if (wr || exp_err(wr, a)) return 32'h0;
        w = a[5:2];
        case (w)
            4'd0:    return 32'hA9B0_0001;
            4'd1:    return {28'h0, m_ctrl};
            4'd2:    return {m_err, m_wr};
            default: return m_scr[w];
        endcase
    endfunction

    task automatic model_commit(input logic wr, input logic [31:0] a, input logic [31:0] d);
        if (exp_err(wr, a)) begin
            if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
        end else if (wr) begin
            if (m_wr != 16'hFFFF) m_wr = m_wr + 16'd1;
            if (a == 32'h4) m_ctrl = d[3:0];
            else if (a >= 32'hC) m_scr[a[5:2]] = d;
        end
    endtask

    // One full transfer, entered and left 1 time unit after a rising edge so
    // that another call continues back-to-back with no idle cycle.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rdata);
        exp_t e;
        int   w;
        e.data  = exp_data(wr, a);
        e.err   = exp_err(wr, a);
        e.waits = int'(m_ctrl);
        sb.push_back(e);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        w = 0;
        while (!PREADY && w < 40) begin
            @(posedge PCLK); #1;
            w++;
        end
        e = sb.pop_front();
        checks++;
        if (PREADY !== 1'b1) begin
            errors++;
            $display("FAIL pready_timeout addr=%h got=%b exp=1", a, PREADY);
        end
        checks++;
        if (PRDATA !== e.data) begin
            errors++;
            $display("FAIL prdata addr=%h wr=%b got=%h exp=%h", a, wr, PRDATA, e.data);
        end
        checks++;
        if (PSLVERR !== e.err) begin
            errors++;
            $display("FAIL pslverr addr=%h wr=%b got=%b exp=%b", a, wr, PSLVERR, e.err);
        end
        checks++;
        if (w != e.waits) begin
            errors++;
            $display("FAIL wait_cycles addr=%h got=%0d exp=%0d", a, w, e.waits);
        end
        rdata = PRDATA;
        @(posedge PCLK); #1;
        model_commit(wr, a, d);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 32'h0; PWDATA = 32'h0;
        model_reset();
        #12;
        checks++;
        if (PREADY !== 1'b0 || PSLVERR !== 1'b0 || PRDATA !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%b/%b/%h exp=0/0/0", PREADY, PSLVERR, PRDATA);
        end
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        xfer(1'b0, 32'h0, 32'h0, r);
        checks++;
        if (r !== 32'hA9B0_0001) begin
            errors++;
            $display("FAIL id_literal got=%h exp=a9b00001", r);
        end
        xfer(1'b0, 32'h4, 32'h0, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL ctrl_reset got=%h exp=00000000", r);
        end
    endtask

    task automatic test_write_read();
        logic [31:0] r;
        xfer(1'b1, 32'h10, 32'hDEAD_BEEF, r);
        xfer(1'b0, 32'h10, 32'h0, r);
        checks++;
        if (r !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL raw_readback got=%h exp=deadbeef", r);
        end
        xfer(1'b0, 32'h8, 32'h0, r);
        checks++;
        if (r !== 32'h0000_0001) begin
            errors++;
            $display("FAIL status_after_write got=%h exp=00000001", r);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] r;
        xfer(1'b1, 32'h4, 32'h0000_0003, r);
        xfer(1'b0, 32'h10, 32'h0, r);
        xfer(1'b0, 32'h8, 32'h0, r);
        checks++;
        if (r[15:0] !== 16'h0002) begin
            errors++;
            $display("FAIL wr_cnt_after_ctrl got=%h exp=0002", r[15:0]);
        end
    endtask

    task automatic test_errors();
        logic [31:0] r;
        xfer(1'b1, 32'h11, 32'h5555_5555, r);
        xfer(1'b1, 32'h8, 32'hFFFF_FFFF, r);
        xfer(1'b0, 32'h40, 32'h0, r);
        xfer(1'b0, 32'h8, 32'h0, r);
        checks++;
        if (r !== 32'h0003_0002) begin
            errors++;
            $display("FAIL status_after_errors got=%h exp=00030002", r);
        end
        xfer(1'b0, 32'h8000_0010, 32'h0, r);
        xfer(1'b1, 32'h0, 32'h1234_5678, r);
        xfer(1'b0, 32'h0, 32'h0, r);
        xfer(1'b0, 32'h10, 32'h0, r);
    endtask

    task automatic test_stray_enable();
        logic [31:0] r;
        PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b1; PADDR = 32'hC; PWDATA = 32'hFFFF_0000;
        for (int i = 0; i < 3; i++) begin
            @(posedge PCLK); #1;
            checks++;
            if (PREADY !== 1'b0) begin
                errors++;
                $display("FAIL stray_enable_pready cycle=%0d got=%b exp=0", i, PREADY);
            end
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        xfer(1'b0, 32'hC, 32'h0, r);
        xfer(1'b0, 32'h8, 32'h0, r);
    endtask

    task automatic test_abort();
        logic [31:0] r;
        xfer(1'b1, 32'h4, 32'h0000_0002, r);
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h14; PWDATA = 32'h0000_1234;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        checks++;
        if (PREADY !== 1'b0) begin
            errors++;
            $display("FAIL abort_first_access got=%b exp=0", PREADY);
        end
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        checks++;
        if (PREADY !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got=%b exp=0", PREADY);
        end
        xfer(1'b0, 32'h14, 32'h0, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL abort_no_write got=%h exp=00000000", r);
        end
        xfer(1'b0, 32'h8, 32'h0, r);
    endtask

    task automatic test_reset_mid();
        logic [31:0] r;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h18; PWDATA = 32'h0000_CAFE;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        @(posedge PCLK); #1;
        checks++;
        if (PREADY !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pre_ready got=%b exp=1", PREADY);
        end
        PRESETn = 1'b0;
        #1;
        checks++;
        if (PREADY !== 1'b0 || PSLVERR !== 1'b0 || PRDATA !== 32'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs got=%b/%b/%h exp=0/0/0", PREADY, PSLVERR, PRDATA);
        end
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        model_reset();
        @(posedge PCLK); #1;
        xfer(1'b0, 32'h18, 32'h0, r);
        checks++;
        if (r !== 32'h0) begin
            errors++;
            $display("FAIL write_lost got=%h exp=00000000", r);
        end
        xfer(1'b0, 32'h4, 32'h0, r);
        xfer(1'b0, 32'h8, 32'h0, r);
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic [31:0] a;
        xfer(1'b1, 32'h4, 32'h0000_0001, r);
        for (int i = 3; i < 16; i++) begin
            a = 32'(i * 4);
            xfer(1'b1, a, $urandom, r);
        end
        xfer(1'b1, 32'h4, 32'h0000_0000, r);
        for (int i = 3; i < 16; i++) begin
            a = 32'(i * 4);
            xfer(1'b0, a, 32'h0, r);
        end
        xfer(1'b0, 32'h8, 32'h0, r);
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wait_states();
        test_errors();
        test_stray_enable();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
